load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: single-request load/store unit sitting between the core
// pipeline and a word-wide data memory with combinational read data.
// Loads take IDLE->READ->RESP, word stores IDLE->WRITE->RESP, sub-word
// stores do read-modify-write IDLE->READ->WRITE->RESP, and rejected
// requests go straight IDLE->RESP with rsp_err_o set.
// Optional feature: define MISALIGN_TRAP_EN to reject misaligned
// halfword/word accesses; otherwise the low address bits are cleared.
module load_store_unit #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 256,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = 32'h1001_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [DATA_WIDTH-1:0] mem_address_o,
  output logic [DATA_WIDTH-1:0] mem_write_data_o,
  output logic                  mem_write_o,
  output logic                  mem_read_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // One past the last valid byte address; one extra bit so the sum cannot wrap.
  localparam logic [DATA_WIDTH:0] END_ADDR =
    {1'b0, BASE_ADDR} + (DATA_WIDTH+1)'(4 * MEMORY_DEPTH);

  state_e                  state_q, state_d;
  logic                    in_reset_q, in_reset_d;
  logic                    write_q, write_d;
  logic [1:0]              size_q, size_d;
  logic                    unsigned_q, unsigned_d;
  logic [DATA_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;

  logic                    accept;
  logic                    req_err;
  logic [DATA_WIDTH-1:0]   req_addr_aligned;
  logic [DATA_WIDTH-1:0]   load_ext;
  logic [DATA_WIDTH-1:0]   store_merged;
  logic [7:0]              byte_sel;
  logic [15:0]             half_sel;

  // Request decode: range/size checks and address alignment.
  always_comb begin
    req_addr_aligned = req_addr_i;
    if (req_size_i == SZ_H) req_addr_aligned[0]   = 1'b0;
    if (req_size_i == SZ_W) req_addr_aligned[1:0] = 2'b00;
    req_err = (req_addr_i < BASE_ADDR) ||
              ({1'b0, req_addr_i} >= END_ADDR) ||
              (req_size_i == 2'b11);
`ifdef MISALIGN_TRAP_EN
    if ((req_size_i == SZ_H && req_addr_i[0]) ||
        (req_size_i == SZ_W && req_addr_i[1:0] != 2'b00))
      req_err = 1'b1;
`endif
  end

  assign accept = req_valid_i & req_ready_o;

  // Next-state and request capture.
  always_comb begin
    state_d    = state_q;
    in_reset_d = 1'b0;
    write_d    = write_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    data_d     = data_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          write_d    = req_write_i;
          size_d     = req_size_i;
          unsigned_d = req_unsigned_i;
          addr_d     = req_addr_aligned;
          wdata_d    = req_wdata_i;
          err_d      = req_err;
          if (req_err)                                 state_d = S_RESP;
          else if (req_write_i && req_size_i == SZ_W)  state_d = S_WRITE;
          else                                         state_d = S_READ;
        end
      end
      S_READ: begin
        data_d  = mem_data_i;
        state_d = write_q ? S_WRITE : S_RESP;
      end
      S_WRITE: state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  // State and request registers; reset aborts any in-flight request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      in_reset_q <= 1'b1;
      write_q    <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_reset_q <= in_reset_d;
      write_q    <= write_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      data_q     <= data_d;
    end
  end

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    byte_sel     = data_q[{addr_q[1:0], 3'b000} +: 8];
    half_sel     = data_q[{addr_q[1], 4'b0000} +: 16];
    load_ext     = data_q;
    store_merged = wdata_q;
    case (size_q)
      SZ_B: begin
        load_ext = unsigned_q ? {{(DATA_WIDTH-8){1'b0}}, byte_sel}
                              : {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
        store_merged = data_q;
        store_merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
      SZ_H: begin
        load_ext = unsigned_q ? {{(DATA_WIDTH-16){1'b0}}, half_sel}
                              : {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
        store_merged = data_q;
        store_merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      default: ;
    endcase
  end

  // Outputs: strobes only in READ/WRITE, response fields only in RESP.
  always_comb begin
    req_ready_o      = (state_q == S_IDLE) && !in_reset_q;
    mem_read_o       = (state_q == S_READ);
    mem_write_o      = (state_q == S_WRITE);
    mem_address_o    = '0;
    mem_write_data_o = '0;
    rsp_valid_o      = (state_q == S_RESP);
    rsp_err_o        = (state_q == S_RESP) && err_q;
    rsp_rdata_o      = '0;
    if (state_q == S_READ || state_q == S_WRITE)
      mem_address_o = {addr_q[DATA_WIDTH-1:2], 2'b00};
    if (state_q == S_WRITE)
      mem_write_data_o = store_merged;
    if (state_q == S_RESP && !err_q && !write_q)
      rsp_rdata_o = load_ext;
  end

endmodule
